mem_sync_pipe: RTL
==================

// Module: mem_sync_pipe
// PURPOSE
//  Parametrised synchronous single-port memory for the training testbenches.
//  Successor to the fixed 8x32 memory. Adds configurable width, depth and
//  read latency (pipelined, back-to-back reads), a data_valid strobe, a
//  post-reset hardware clear FSM with ready, and an error strobe for illegal
//  requests. Single clock; sits directly on the bus interface of the lab bench.
// PARAMETERS
//  DW          8     data width in bits
//  DEPTH       32    number of words, >=2, need not be a power of 2
//  AW          $clog2(DEPTH)  address width (derived; do not override)
//  RD_LAT      1     read latency in clocks, legal 1..4
//  INIT_VALUE  '0    DW-bit value written to every word by the clear FSM
// PORTS
//  clk       in   1    clock, all activity on posedge
//  reset     in   1    synchronous, active-high reset
//  read      in   1    read request, sampled on posedge clk
//  write     in   1    write request, sampled on posedge clk
//  addr      in   AW   word address
//  data_in   in   DW   write data
//  ready     out  1    1 = memory accepts requests (clear complete)
//  data_out  out  DW   read data, valid when data_valid=1, holds otherwise
//  data_valid out 1    one-cycle strobe per completed read
//  error     out  1    one-cycle strobe: illegal request seen previous edge
// BEHAVIOUR
//  Reset: ready=0, data_valid=0, error=0, data_out=0; read pipeline flushed
//   (in-flight reads never produce data_valid); FSM -> CLEAR, clr_ptr=0.
//   Reset asserted mid-clear or mid-read restarts clear from word 0.
//  FSM CLEAR: each clk writes INIT_VALUE to mem[clr_ptr], clr_ptr++;
//   on the edge writing word DEPTH-1 -> RUN; ready=1 from the next cycle.
//   Clear takes exactly DEPTH cycles after reset deasserts. ready=0 in CLEAR.
//  FSM RUN: stays in RUN until reset; ready=1.
//  Request legality, sampled each posedge (error asserted next cycle, 1 clk):
//   - read or write while ready=0           -> ignored, error=1
//   - read=1 and write=1                     -> no access, error=1
//   - addr >= DEPTH with read or write       -> no access, error=1
//   - read=0, write=0                        -> no-op, no error
//  Write (legal, write=1 read=0): mem[addr]<=data_in at that edge; no delay;
//   a read of that address issued on any later edge returns new data.
//  Read (legal, read=1 write=0): issued at edge N -> data_out=mem[addr] and
//   data_valid=1 during cycle after edge N+RD_LAT-1 (RD_LAT=1: next cycle,
//   same timing as the old memory). One read per clk accepted; results
//   return in issue order, one data_valid per read, no bubbles inserted.
//  Read data is captured at issue edge N (write at edge N+1 to the same
//   address does not alter an in-flight read).
//  data_out holds last valid read data when data_valid=0.
//  Illegal requests never disturb memory contents or in-flight reads.
// TESTING
//  1 Clear: DW=8,DEPTH=32,INIT_VALUE=8'hA5; release reset -> ready rises after
//    exactly 32 clks; read all 32 addrs -> every data_out=8'hA5.
//  2 Write/read: write 8'h3C @5, next clk read @5 with RD_LAT=3 -> data_valid
//    3 cycles later with data_out=8'h3C; error stays 0.
//  3 Back-to-back: RD_LAT=2, reads of addr 0..7 on 8 consecutive clks ->
//    8 consecutive data_valid pulses, data in address order, no gaps.
//  4 Illegal: read=write=1 @3; addr=32 on DEPTH=32; request while ready=0 ->
//    error=1 one cycle each, mem[3] unchanged, no data_valid.
//  5 Reset mid-op: DEPTH=20 (non-pow2), issue 2 reads at RD_LAT=4, assert reset
//    1 clk -> no data_valid from them, ready=0, clear re-runs 20 clks.
//  6 Read-then-write same addr: read @7 at edge N, write 8'hFF @7 at N+1 ->
//    returned data is old value; subsequent read returns 8'hFF.

Source files
------------

// File: rtl/mem_sync_pipe_if.sv
// Request/response bus between the lab bench and mem_sync_pipe.
// Requests are sampled on the rising clock edge; responses are registered.
interface mem_sync_pipe_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
);
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          error;

  modport master (
    output read, write, addr, data_in,
    input  ready, data_out, data_valid, error
  );

  modport slave (
    input  read, write, addr, data_in,
    output ready, data_out, data_valid, error
  );
endinterface

// File: rtl/mem_sync_pipe.sv
// Single-port synchronous memory with post-reset clear, pipelined reads
// of configurable latency, and a one-cycle error strobe for illegal requests.
module mem_sync_pipe #(
  parameter int unsigned   DW         = 8,
  parameter int unsigned   DEPTH      = 32,
  parameter int unsigned   RD_LAT     = 1,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic           clk,
  input  logic           reset,
  mem_sync_pipe_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic          ready_q;
  logic          error_q;
  logic [DW-1:0] mem [DEPTH];
  logic [RD_LAT-1:0] pv;
  logic [DW-1:0] pd [RD_LAT];

  logic addr_bad_c;
  logic illegal_c;
  logic rd_ok_c;
  logic wr_ok_c;

  // Request legality; ready_q gates everything until the clear has finished
  always_comb begin
    addr_bad_c = {1'b0, bus.addr} >= PW'(DEPTH);
    illegal_c  = (bus.read | bus.write) &
                 (~ready_q | (bus.read & bus.write) | addr_bad_c);
    rd_ok_c    = bus.read  & ~bus.write & ready_q & ~addr_bad_c;
    wr_ok_c    = bus.write & ~bus.read  & ready_q & ~addr_bad_c;
  end

  // Clear FSM, ready and error strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      error_q <= illegal_c;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN:     ready_q <= 1'b1;
        default: state   <= CLEAR;
      endcase
    end
  end

  // Storage: clear writes and user writes are exclusive since ready_q=0 in CLEAR
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= INIT_VALUE;
      end else if (wr_ok_c) begin
        mem[bus.addr] <= bus.data_in;
      end
    end
  end

  // Read pipeline: data captured at issue; each stage loads only on a valid
  // beat so the last stage holds the most recent read data between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= rd_ok_c;
      if (rd_ok_c) begin
        pd[0] <= mem[bus.addr];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
        end
      end
    end
  end

  assign bus.ready      = ready_q;
  assign bus.error      = error_q;
  assign bus.data_valid = pv[RD_LAT-1];
  assign bus.data_out   = pd[RD_LAT-1];
endmodule
